// File: rtl/motor_pwm_pkg.sv
// Shared definitions for the H-bridge PWM controller: direction codes,
// per-channel state encoding and the duty clamp helper.
package motor_pwm_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_DEAD  = 2'd3
  } chan_state_e;

  function automatic int unsigned clamp_duty(int unsigned duty, int unsigned limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/motor_pwm_if.sv
// Command/drive bundle between the motion-control FSM (master) and the PWM block (slave).
interface motor_pwm_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 11
);
  logic                    en;
  logic [2*N_CH-1:0]       dir_cmd;
  logic [CNT_W*N_CH-1:0]   duty_cmd;
  logic [N_CH-1:0]         f_pwm;
  logic [N_CH-1:0]         b_pwm;
  logic [N_CH-1:0]         ch_dead;
  logic                    period_tick;

  modport master (output en, dir_cmd, duty_cmd,
                  input  f_pwm, b_pwm, ch_dead, period_tick);
  modport slave  (input  en, dir_cmd, duty_cmd,
                  output f_pwm, b_pwm, ch_dead, period_tick);
endinterface

// File: rtl/motor_pwm_chan.sv
// One H-bridge channel: direction FSM with dead-time interlock, duty slew
// limit and registered forward/reverse drive outputs.
module motor_pwm_chan
  import motor_pwm_pkg::*;
#(
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned DEAD_PER  = 2,
  parameter int unsigned RAMP_STEP = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bnd,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       dir_cmd,
  input  logic [CNT_W-1:0] duty_cmd,
  output logic             f_pwm,
  output logic             b_pwm,
  output logic             ch_dead
);

  localparam int unsigned DEAD_W = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PER - 1);

  chan_state_e       state, state_nxt;
  logic              rev, rev_nxt;
  logic [CNT_W-1:0]  duty_act, duty_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;
  logic [CNT_W-1:0]  start_duty, ramp_duty;
  int unsigned       dc, da;
  logic              same_dir, go_start;

  // Slew-limited duty targets: first step out of STOP and per-period approach
  always_comb begin
    dc         = clamp_duty(32'(duty_cmd), PERIOD);
    da         = 32'(duty_act);
    start_duty = CNT_W'(clamp_duty(dc, RAMP_STEP));
    if (dc > da) ramp_duty = CNT_W'(clamp_duty(dc, da + RAMP_STEP));
    else         ramp_duty = (da - dc > RAMP_STEP) ? CNT_W'(da - RAMP_STEP) : CNT_W'(dc);
  end

  assign same_dir = ((dir_cmd == DIR_FWD) && !rev) || ((dir_cmd == DIR_REV) && rev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_STOP;
      rev      <= 1'b0;
      duty_act <= '0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rev      <= rev_nxt;
      duty_act <= duty_nxt;
      dead_cnt <= dead_nxt;
    end
  end

  // Commands only take effect at the period boundary
  always_comb begin
    state_nxt = state;
    rev_nxt   = rev;
    duty_nxt  = duty_act;
    dead_nxt  = dead_cnt;
    go_start  = 1'b0;
    if (!en) begin
      state_nxt = ST_STOP;
      rev_nxt   = 1'b0;
      duty_nxt  = '0;
      dead_nxt  = '0;
    end else if (bnd) begin
      case (state)
        ST_STOP: go_start = 1'b1;
        ST_RUN: begin
          if (dir_cmd == DIR_COAST) begin
            state_nxt = ST_STOP;
            duty_nxt  = '0;
          end else if (same_dir) begin
            duty_nxt  = ramp_duty;
          end else begin
            state_nxt = ST_DEAD;
            dead_nxt  = DEAD_LOAD;
            duty_nxt  = '0;
          end
        end
        ST_BRAKE: begin
          if (dir_cmd == DIR_COAST) begin
            state_nxt = ST_STOP;
          end else if (dir_cmd != DIR_BRAKE) begin
            state_nxt = ST_DEAD;
            dead_nxt  = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (dead_cnt != '0) dead_nxt = dead_cnt - DEAD_W'(1);
          else                go_start = 1'b1;
        end
        default: state_nxt = ST_STOP;
      endcase
      if (go_start) begin
        case (dir_cmd)
          DIR_FWD, DIR_REV: begin
            state_nxt = ST_RUN;
            rev_nxt   = (dir_cmd == DIR_REV);
            duty_nxt  = start_duty;
          end
          DIR_BRAKE: state_nxt = ST_BRAKE;
          default: begin
            state_nxt = ST_STOP;
            duty_nxt  = '0;
          end
        endcase
      end
    end
  end

  // Drive pins lag the counter value they were computed from by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pwm   <= 1'b0;
      b_pwm   <= 1'b0;
      ch_dead <= 1'b0;
    end else begin
      f_pwm   <= en && (((state == ST_RUN) && !rev && (cnt < duty_act)) || (state == ST_BRAKE));
      b_pwm   <= en && (((state == ST_RUN) &&  rev && (cnt < duty_act)) || (state == ST_BRAKE));
      ch_dead <= (state_nxt == ST_DEAD);
    end
  end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel H-bridge PWM generator: shared period counter and boundary
// strobe feeding one motor_pwm_chan per drive motor.
module motor_pwm_ctrl
  import motor_pwm_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned DEAD_PER  = 2,
  parameter int unsigned RAMP_STEP = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  motor_pwm_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bnd;
  logic             tick;

  assign bnd     = bus.en && (cnt == LAST);
  assign cnt_nxt = (!bus.en || (cnt == LAST)) ? '0 : cnt + CNT_W'(1);

  // period_tick is registered so it is high exactly while cnt == PERIOD-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= bus.en && (cnt_nxt == LAST);
    end
  end

  assign bus.period_tick = tick;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_pwm_chan #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .DEAD_PER  (DEAD_PER),
      .RAMP_STEP (RAMP_STEP)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en),
      .bnd      (bnd),
      .cnt      (cnt),
      .dir_cmd  (bus.dir_cmd[2*i +: 2]),
      .duty_cmd (bus.duty_cmd[CNT_W*i +: CNT_W]),
      .f_pwm    (bus.f_pwm[i]),
      .b_pwm    (bus.b_pwm[i]),
      .ch_dead  (bus.ch_dead[i])
    );
  end

endmodule
